// File: rtl/gate_test_sequencer_if.sv
// Board-side signal bundle for the gate self-test sequencer.
// master = sequencer, slave = gate/button side.
interface gate_test_sequencer_if;
  logic       start_btn;
  logic       gate_f;
  logic       gate_a;
  logic       gate_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;
  logic [1:0] vec_idx;

  modport master (
    input  start_btn, gate_f,
    output gate_a, gate_b, busy, done,
    output pass, fail_mask, vec_idx
  );

  modport slave (
    output start_btn, gate_f,
    input  gate_a, gate_b, busy, done,
    input  pass, fail_mask, vec_idx
  );
endinterface

// File: rtl/gate_test_sequencer.sv
// Push-button self-test of a 2-input gate: steps all four
// input vectors, samples the output, reports a fail mask.
module gate_test_sequencer #(
  parameter int         SETTLE_CYCLES   = 25000000,
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter logic [3:0] EXPECT          = 4'b1000
) (
  input  logic                  clk,
  input  logic                  rst,
  gate_test_sequencer_if.master bus
);
  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SET_LD = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic          r_btn_s1, r_btn_s2;
  logic          r_db, r_db_q;
  logic [DW-1:0] r_db_cnt;
  logic          r_f_s1, r_f_s2;
  logic [1:0]    r_state;
  logic [SW-1:0] r_cnt;
  logic [1:0]    r_vec;
  logic [3:0]    r_mask;
  logic          r_a, r_b;
  logic          r_busy, r_done, r_pass;

  logic          w_start;
  logic          w_miss;
  logic [3:0]    w_mask_upd;
  logic [1:0]    w_vec_nx;

  assign w_start    = r_db & ~r_db_q;
  assign w_miss     = r_f_s2 != EXPECT[r_vec];
  assign w_mask_upd = r_mask | (4'(w_miss) << r_vec);
  assign w_vec_nx   = r_vec + 2'd1;

  // Button: 2-FF sync, then level must hold DEBOUNCE_CYCLES to flip
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_db     <= 1'b0;
      r_db_q   <= 1'b0;
      r_db_cnt <= '0;
      r_f_s1   <= 1'b0;
      r_f_s2   <= 1'b0;
    end else begin
      r_btn_s1 <= bus.start_btn;
      r_btn_s2 <= r_btn_s1;
      r_db_q   <= r_db;
      r_f_s1   <= bus.gate_f;
      r_f_s2   <= r_f_s1;
      if (r_btn_s2 == r_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_MAX) begin
        r_db     <= r_btn_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_vec   <= 2'd0;
      r_mask  <= 4'd0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (w_start) begin
            r_mask  <= 4'd0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_vec   <= 2'd0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_cnt   <= SET_LD;
            r_busy  <= 1'b1;
            r_state <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_cnt == '0) r_state <= SAMPLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        SAMPLE: begin
          r_mask <= w_mask_upd;
          if (r_vec == 2'd3) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_mask_upd == 4'd0);
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_state <= DONE;
          end else begin
            r_vec   <= w_vec_nx;
            r_a     <= w_vec_nx[1];
            r_b     <= w_vec_nx[0];
            r_cnt   <= SET_LD;
            r_state <= SETTLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gate_a    = r_a;
  assign bus.gate_b    = r_b;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.fail_mask = r_mask;
  assign bus.vec_idx   = r_vec;
endmodule
